// File: rtl/pg_ctrl_pkg.sv
// Shared definitions for the power-gating controller: bus widths, port
// status codes and the per-port gating FSM state encoding.
package pg_ctrl_pkg;

    // Number of router ports, ordered [S,N,W,E] with port 0 at the LSB.
    localparam int NUM_PORTS = 4;

    // Width of one per-port load count (saturating counter in loadTrack).
    localparam int PG_PORT_LOAD_SIZE = 8;

    // Width of the router-wide load sum (four saturated port counts).
    localparam int PG_ROUTER_LOAD_SIZE = 10;

    // Width of one port status field.
    localparam int PORT_STAT_SIZE = 1;

    // Port status codes driven back to loadTrack and the datapath.
    localparam logic [PORT_STAT_SIZE-1:0] STAT_ACTIVE   = 1'b0;
    localparam logic [PORT_STAT_SIZE-1:0] STAT_INACTIVE = 1'b1;

    // Per-port gating FSM states.
    typedef enum logic [1:0] {
        PG_ACTIVE   = 2'd0,
        PG_DRAIN    = 2'd1,
        PG_INACTIVE = 2'd2,
        PG_WAKE     = 2'd3
    } pgState_t;

    // Counter width for a counter that must hold 0..n-1 (at least 1 bit).
    function automatic int ctrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A port occupies a gating slot while draining or asleep.
    function automatic logic isGated(input pgState_t s);
        return (s == PG_DRAIN) || (s == PG_INACTIVE);
    endfunction

endpackage

// File: rtl/pg_ctrl_port_fsm.sv
// Per-port power-gating FSM: ACTIVE -> DRAIN -> INACTIVE -> WAKE -> ACTIVE.
// Holds the DRAIN acknowledge timeout, the WAKE latency counter and the
// registered sleepReq/portStatus outputs for one link.
module pg_port_fsm
    import pg_ctrl_pkg::*;
#(
    parameter int ACK_TMO  = 16,
    parameter int WAKE_LAT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gateGrant,
    input  logic                      wakeReq,
    input  logic                      sleepAck,
    input  logic                      nbrWake,
    output pgState_t                  state,
    output logic                      sleepReq,
    output logic [PORT_STAT_SIZE-1:0] portStatus
);

    localparam int TMO_W  = ctrWidth(ACK_TMO);
    localparam int WAKE_W = ctrWidth(WAKE_LAT);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TMO - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);

    pgState_t          nextState;
    logic [TMO_W-1:0]  tmoCnt;
    logic [WAKE_W-1:0] wakeCnt;
    logic              tmoExpired;
    logic              wakeDone;

    // tmoCnt counts completed DRAIN cycles; the last one without an ack aborts.
    assign tmoExpired = (tmoCnt == TMO_LAST);
    assign wakeDone   = (wakeCnt == WAKE_LAST);

    // Next-state logic. In DRAIN a neighbour wake beats a same-cycle ack,
    // and an ack arriving together with timeout expiry still completes sleep.
    always_comb begin
        nextState = state;
        case (state)
            PG_ACTIVE: begin
                if (gateGrant) nextState = PG_DRAIN;
            end
            PG_DRAIN: begin
                if (nbrWake)         nextState = PG_ACTIVE;
                else if (sleepAck)   nextState = PG_INACTIVE;
                else if (tmoExpired) nextState = PG_ACTIVE;
            end
            PG_INACTIVE: begin
                if (nbrWake || wakeReq) nextState = PG_WAKE;
            end
            PG_WAKE: begin
                if (wakeDone) nextState = PG_ACTIVE;
            end
            default: nextState = PG_ACTIVE;
        endcase
    end

    // State register; sleepReq and portStatus are registered from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PG_ACTIVE;
            sleepReq   <= 1'b0;
            portStatus <= STAT_ACTIVE;
        end else begin
            state      <= nextState;
            sleepReq   <= (nextState == PG_DRAIN);
            portStatus <= ((nextState == PG_INACTIVE) || (nextState == PG_WAKE))
                          ? STAT_INACTIVE : STAT_ACTIVE;
        end
    end

    // Residency counters: cleared on every entry, advanced while staying.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmoCnt  <= '0;
            wakeCnt <= '0;
        end else begin
            tmoCnt  <= ((state == PG_DRAIN) && (nextState == PG_DRAIN))
                       ? tmoCnt + 1'b1 : '0;
            wakeCnt <= ((state == PG_WAKE) && (nextState == PG_WAKE))
                       ? wakeCnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/pg_ctrl.sv
// Router power-gating controller. Runs the epoch counter, raises pgEnable in
// the last cycle of each epoch, and in that cycle decides per port whether to
// start gating (limited to MAX_GATED ports in DRAIN/INACTIVE) or to wake.
//
// Sleep handshake: sleepReq[i] is a level held for as long as port i is in
// DRAIN. The neighbour answers with sleepAck[i]; the first cycle with both
// sleepReq[i] and sleepAck[i] high completes the handshake and the port goes
// INACTIVE on that edge. sleepAck[i] is ignored whenever sleepReq[i] is low.
// If ACK_TMO DRAIN cycles pass without an ack, or nbrWake[i] arrives, the
// request is withdrawn and the port returns to ACTIVE.
module pg_ctrl
    import pg_ctrl_pkg::*;
#(
    parameter int EPOCH_LEN = 256,
    parameter int LOW_TH    = 8,
    parameter int HIGH_TH   = 64,
    parameter int ROUTER_TH = 96,
    parameter int MAX_GATED = 2,
    parameter int WAKE_LAT  = 4,
    parameter int ACK_TMO   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS*PG_PORT_LOAD_SIZE-1:0] portLoad,
    input  logic [PG_ROUTER_LOAD_SIZE-1:0]        routerLoad,
    input  logic [NUM_PORTS-1:0]                  sleepAck,
    input  logic [NUM_PORTS-1:0]                  nbrWake,
    output logic                                  pgEnable,
    output logic [NUM_PORTS-1:0]                  sleepReq,
    output logic [NUM_PORTS*PORT_STAT_SIZE-1:0]   portStatus,
    output logic [NUM_PORTS*2-1:0]                dbgState
);

    localparam int EPOCH_W = ctrWidth(EPOCH_LEN);
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCH_LEN - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_PRE  = EPOCH_W'(EPOCH_LEN - 2);

    // Thresholds zero-extended to the load widths; saturated counts compare as-is.
    localparam logic [PG_PORT_LOAD_SIZE-1:0]   LOW_TH_V    = PG_PORT_LOAD_SIZE'(LOW_TH);
    localparam logic [PG_PORT_LOAD_SIZE-1:0]   HIGH_TH_V   = PG_PORT_LOAD_SIZE'(HIGH_TH);
    localparam logic [PG_ROUTER_LOAD_SIZE-1:0] ROUTER_TH_V = PG_ROUTER_LOAD_SIZE'(ROUTER_TH);

    localparam int SLOT_W = ctrWidth(NUM_PORTS + 1);
    localparam logic [SLOT_W-1:0] MAX_GATED_V = SLOT_W'(MAX_GATED);

    logic [EPOCH_W-1:0]           epochCnt;
    logic [PG_PORT_LOAD_SIZE-1:0] load [NUM_PORTS];
    pgState_t                     portState [NUM_PORTS];
    logic                         routerBusy;
    logic [NUM_PORTS-1:0]         candidate;
    logic [NUM_PORTS-1:0]         gateGrant;
    logic [NUM_PORTS-1:0]         wakeReq;
    logic [SLOT_W-1:0]            gatedCnt;
    logic [SLOT_W-1:0]            slotsUsed;

    // Epoch counter; pgEnable is registered so it is high exactly while the
    // counter sits at EPOCH_LEN-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epochCnt <= '0;
            pgEnable <= 1'b0;
        end else begin
            epochCnt <= (epochCnt == EPOCH_LAST) ? '0 : epochCnt + 1'b1;
            pgEnable <= (epochCnt == EPOCH_PRE);
        end
    end

    assign routerBusy = (routerLoad >= ROUTER_TH_V);

    // Bus split, per-port decision inputs and debug state merge.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign load[i] = portLoad[i*PG_PORT_LOAD_SIZE +: PG_PORT_LOAD_SIZE];

        // A port asking to be woken by its neighbour is never a gate candidate.
        assign candidate[i] = pgEnable && (portState[i] == PG_ACTIVE) && !nbrWake[i]
                              && (load[i] < LOW_TH_V) && !routerBusy;

        assign wakeReq[i] = pgEnable && ((load[i] >= HIGH_TH_V) || routerBusy);

        assign dbgState[2*i +: 2] = portState[i];

        pg_port_fsm #(
            .ACK_TMO  (ACK_TMO),
            .WAKE_LAT (WAKE_LAT)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .gateGrant  (gateGrant[i]),
            .wakeReq    (wakeReq[i]),
            .sleepAck   (sleepAck[i]),
            .nbrWake    (nbrWake[i]),
            .state      (portState[i]),
            .sleepReq   (sleepReq[i]),
            .portStatus (portStatus[i*PORT_STAT_SIZE +: PORT_STAT_SIZE])
        );
    end

    // Count ports currently holding a gating slot (DRAIN or INACTIVE).
    always_comb begin
        gatedCnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gatedCnt = gatedCnt + SLOT_W'(isGated(portState[i]));
        end
    end

    // Slot arbitration: grant candidates lowest index first until the number
    // of gated ports plus new grants reaches MAX_GATED.
    always_comb begin
        gateGrant = '0;
        slotsUsed = gatedCnt;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (candidate[i] && (slotsUsed < MAX_GATED_V)) begin
                gateGrant[i] = 1'b1;
                slotsUsed    = slotsUsed + 1'b1;
            end
        end
    end

endmodule
